// File: rtl/slv_i2c_io_cond_if.sv
// Pad-side SCL/SDA inputs and conditioned levels/strobes exchanged between
// the I2C line-conditioning front end and its consumers.
interface slv_i2c_io_cond_if;
  logic io_scl;
  logic io_sda;
  logic scl;
  logic sda;
  logic rs_io_scl;
  logic fl_io_scl;
  logic rs_io_sda;
  logic fl_io_sda;
  logic start;
  logic stop;
  logic mdl_lw_io_scl;
  logic mdl_hg_io_scl;

  modport slave (
    input  io_scl, io_sda,
    output scl, sda, rs_io_scl, fl_io_scl, rs_io_sda, fl_io_sda,
           start, stop, mdl_lw_io_scl, mdl_hg_io_scl
  );

  modport master (
    output io_scl, io_sda,
    input  scl, sda, rs_io_scl, fl_io_scl, rs_io_sda, fl_io_sda,
           start, stop, mdl_lw_io_scl, mdl_hg_io_scl
  );
endinterface

// File: rtl/slv_i2c_io_cond.sv
// I2C slave line conditioning: synchronise and glitch-filter SCL/SDA, then
// derive edge, START/STOP and mid-phase strobes from the filtered levels.
module slv_i2c_io_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int CNT_W       = 10,
  parameter int DEF_HALF    = 31
) (
  input logic              clk,
  input logic              rst_n,
  slv_i2c_io_cond_if.slave bus
);

  localparam int               FW       = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FW-1:0]    FLT_LAST = FW'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] DEF_H    = CNT_W'(DEF_HALF);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] half_of(input logic [CNT_W-1:0] len);
    logic [CNT_W-1:0] h;
    h = (len == '0) ? DEF_H : (len >> 1);
    return (h == '0) ? CNT_W'(1) : h;
  endfunction

  logic [SYNC_STAGES-1:0] scl_sync_p0, sda_sync_p0;
  logic                   s_scl, s_sda;
  logic                   scl_p1, sda_p1;
  logic [FW-1:0]          scl_cnt_p1, sda_cnt_p1;
  logic                   rs_scl_p1, fl_scl_p1, rs_sda_p1, fl_sda_p1;
  logic                   scl_tgl, sda_tgl, scl_edge;
  logic [CNT_W-1:0]       ph_cnt, len_lw, len_hg, half_lw, half_hg;
  logic                   ph_vld, mid_done, mid_lw, mid_hg;

  // Stage p0: synchronisers, idle-high after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_p0 <= '1;
      sda_sync_p0 <= '1;
    end else begin
      scl_sync_p0 <= {scl_sync_p0[SYNC_STAGES-2:0], bus.io_scl};
      sda_sync_p0 <= {sda_sync_p0[SYNC_STAGES-2:0], bus.io_sda};
    end
  end

  assign s_scl   = scl_sync_p0[SYNC_STAGES-1];
  assign s_sda   = sda_sync_p0[SYNC_STAGES-1];
  assign scl_tgl = (s_scl != scl_p1) && (scl_cnt_p1 == FLT_LAST);
  assign sda_tgl = (s_sda != sda_p1) && (sda_cnt_p1 == FLT_LAST);

  // Stage p1: glitch filters; strobes register together with the new level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_p1     <= 1'b1;
      sda_p1     <= 1'b1;
      scl_cnt_p1 <= '0;
      sda_cnt_p1 <= '0;
      rs_scl_p1  <= 1'b0;
      fl_scl_p1  <= 1'b0;
      rs_sda_p1  <= 1'b0;
      fl_sda_p1  <= 1'b0;
    end else begin
      rs_scl_p1 <= scl_tgl & s_scl;
      fl_scl_p1 <= scl_tgl & ~s_scl;
      rs_sda_p1 <= sda_tgl & s_sda;
      fl_sda_p1 <= sda_tgl & ~s_sda;
      if (scl_tgl) scl_p1 <= s_scl;
      if (sda_tgl) sda_p1 <= s_sda;
      scl_cnt_p1 <= (s_scl == scl_p1 || scl_tgl) ? '0 : scl_cnt_p1 + FW'(1);
      sda_cnt_p1 <= (s_sda == sda_p1 || sda_tgl) ? '0 : sda_cnt_p1 + FW'(1);
    end
  end

  assign scl_edge = rs_scl_p1 | fl_scl_p1;
  assign half_lw  = half_of(len_lw);
  assign half_hg  = half_of(len_hg);
  assign mid_lw   = ~scl_p1 & (ph_cnt == half_lw) & ~scl_edge & ~mid_done;
  assign mid_hg   =  scl_p1 & (ph_cnt == half_hg) & ~scl_edge & ~mid_done;

  // Phase measurement. The idle-high stretch after reset is not a real SCL
  // high phase, so ph_vld keeps it from being recorded as one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_cnt   <= '0;
      len_lw   <= '0;
      len_hg   <= '0;
      ph_vld   <= 1'b0;
      mid_done <= 1'b0;
    end else if (scl_tgl) begin
      ph_cnt   <= '0;
      ph_vld   <= 1'b1;
      mid_done <= 1'b0;
      if (s_scl)       len_lw <= sat_inc(ph_cnt);
      else if (ph_vld) len_hg <= sat_inc(ph_cnt);
    end else begin
      ph_cnt <= sat_inc(ph_cnt);
      if (mid_lw | mid_hg) mid_done <= 1'b1;
    end
  end

  assign bus.scl           = scl_p1;
  assign bus.sda           = sda_p1;
  assign bus.rs_io_scl     = rs_scl_p1;
  assign bus.fl_io_scl     = fl_scl_p1;
  assign bus.rs_io_sda     = rs_sda_p1;
  assign bus.fl_io_sda     = fl_sda_p1;
  assign bus.start         = fl_sda_p1 & scl_p1;
  assign bus.stop          = rs_sda_p1 & scl_p1;
  assign bus.mdl_lw_io_scl = mid_lw;
  assign bus.mdl_hg_io_scl = mid_hg;

endmodule

// File: tb/tb_slv_i2c_io_cond.sv
// Directed bench for slv_i2c_io_cond: filtering, edge/START/STOP strobes,
// mid-phase timing, counter saturation and asynchronous reset.
`timescale 1ns/1ps
module tb_slv_i2c_io_cond;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0;
  int   n_rs_scl, n_fl_scl, n_rs_sda, n_fl_sda, n_start, n_stop, n_mlw, n_mhg;
  int   t_rs_scl, t_fl_scl, t_rs_sda, t_fl_sda, t_mlw, t_mhg;

  slv_i2c_io_cond_if bus ();

  slv_i2c_io_cond #(
    .SYNC_STAGES(2), .FILT_LEN(4), .CNT_W(10), .DEF_HALF(31)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic clr();
    n_rs_scl = 0; n_fl_scl = 0; n_rs_sda = 0; n_fl_sda = 0;
    n_start = 0; n_stop = 0; n_mlw = 0; n_mhg = 0;
    t_rs_scl = -100000; t_fl_scl = -100000; t_rs_sda = -100000;
    t_fl_sda = -100000; t_mlw = -100000; t_mhg = -100000;
  endtask

  // One clock; outputs sampled 1 ns after the edge, strobes tallied.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.rs_io_scl)     begin n_rs_scl++; t_rs_scl = cyc; end
    if (bus.fl_io_scl)     begin n_fl_scl++; t_fl_scl = cyc; end
    if (bus.rs_io_sda)     begin n_rs_sda++; t_rs_sda = cyc; end
    if (bus.fl_io_sda)     begin n_fl_sda++; t_fl_sda = cyc; end
    if (bus.start)         n_start++;
    if (bus.stop)          n_stop++;
    if (bus.mdl_lw_io_scl) begin n_mlw++; t_mlw = cyc; end
    if (bus.mdl_hg_io_scl) begin n_mhg++; t_mhg = cyc; end
  endtask

  // Drive SCL to lvl for n cycles; if exp_mid >= 0 expect exactly one mid
  // strobe exp_mid cycles after the filtered edge opening the phase.
  task automatic scl_phase(input logic lvl, input int n, input int exp_mid, input string tag);
    int m0;
    bus.io_scl = lvl;
    m0 = lvl ? n_mhg : n_mlw;
    repeat (n) step();
    if (exp_mid >= 0) begin
      chk({tag, "_cnt"}, (lvl ? n_mhg : n_mlw) - m0, 1);
      chk({tag, "_dly"}, lvl ? (t_mhg - t_rs_scl) : (t_mlw - t_fl_scl), exp_mid);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.io_scl = 1'b1;
    bus.io_sda = 1'b1;
    clr();

    // Reset hold with idle lines
    repeat (100) step();
    chk("rst_scl", int'(bus.scl), 1);
    chk("rst_sda", int'(bus.sda), 1);
    chk("rst_strobes", n_rs_scl + n_fl_scl + n_rs_sda + n_fl_sda + n_start + n_stop + n_mlw + n_mhg, 0);

    // Release with SDA low: START after SYNC_STAGES + FILT_LEN cycles
    bus.io_sda = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("rel_fl_sda_early", n_fl_sda, 0);
    step();
    chk("rel_fl_sda_at6", int'(bus.fl_io_sda), 1);
    chk("rel_start_at6", int'(bus.start), 1);
    repeat (10) step();
    chk("rel_fl_sda_once", n_fl_sda, 1);
    chk("rel_start_once", n_start, 1);
    bus.io_sda = 1'b1;
    repeat (12) step();
    chk("rel_stop", n_stop, 1);

    // Glitch rejection and minimum accepted pulse
    clr();
    bus.io_sda = 1'b0; repeat (3) step();
    bus.io_sda = 1'b1; repeat (10) step();
    chk("glitch3_sda", int'(bus.sda), 1);
    chk("glitch3_edges", n_fl_sda + n_rs_sda + n_start + n_stop, 0);
    bus.io_sda = 1'b0; repeat (4) step();
    bus.io_sda = 1'b1; repeat (12) step();
    chk("pulse4_fl", n_fl_sda, 1);
    chk("pulse4_start", n_start, 1);
    chk("pulse4_rs", n_rs_sda, 1);
    chk("pulse4_stop", n_stop, 1);

    // Square wave from reset; then varied lengths to prove the measurement
    rst_n = 1'b0;
    repeat (2) step();
    clr();
    rst_n = 1'b1;
    for (int p = 0; p < 3; p++) begin
      scl_phase(1'b0, 63, 31, $sformatf("sq_lo%0d", p));
      scl_phase(1'b1, 62, 31, $sformatf("sq_hi%0d", p));
    end
    scl_phase(1'b0, 40, 31, "lo40");
    scl_phase(1'b1, 50, 31, "hi50");
    scl_phase(1'b0, 63, 20, "lo_after40");
    scl_phase(1'b1, 62, 25, "hi_after50");
    chk("sq_no_start_stop", n_start + n_stop, 0);

    // Long low phase: counter saturation, single strobe, half of 1023
    scl_phase(1'b0, 1500, 31, "sat_lo");
    chk("sat_ph_cnt", int'(dut.ph_cnt), 1023);
    scl_phase(1'b1, 62, 31, "sat_hi");
    scl_phase(1'b0, 600, 511, "after_sat_lo");

    // SDA activity while SCL low; simultaneous SCL/SDA edges
    bus.io_scl = 1'b1; repeat (20) step();
    bus.io_scl = 1'b0; repeat (20) step();
    clr();
    bus.io_sda = 1'b0; repeat (10) step();
    bus.io_sda = 1'b1; repeat (10) step();
    chk("lo_sda_rs", n_rs_sda, 1);
    chk("lo_sda_fl", n_fl_sda, 1);
    chk("lo_sda_no_ss", n_start + n_stop, 0);
    clr();
    bus.io_scl = 1'b1; bus.io_sda = 1'b0;
    repeat (10) step();
    chk("simA_same_cycle", t_rs_scl - t_fl_sda, 0);
    chk("simA_start", n_start, 1);
    clr();
    bus.io_scl = 1'b0; bus.io_sda = 1'b1;
    repeat (10) step();
    chk("simB_same_cycle", t_fl_scl - t_rs_sda, 0);
    chk("simB_rs_sda", n_rs_sda, 1);
    chk("simB_no_stop", n_stop, 0);

    // Asynchronous reset mid-byte with SCL and SDA low
    bus.io_sda = 1'b0; repeat (10) step();
    chk("pre_rst_sda", int'(bus.sda), 0);
    rst_n = 1'b0;
    #1;
    chk("arst_scl", int'(bus.scl), 1);
    chk("arst_sda", int'(bus.sda), 1);
    chk("arst_strobes", int'({bus.rs_io_scl, bus.fl_io_scl, bus.rs_io_sda, bus.fl_io_sda,
                              bus.start, bus.stop, bus.mdl_lw_io_scl, bus.mdl_hg_io_scl}), 0);
    bus.io_sda = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    clr();
    repeat (60) step();
    chk("post_rst_fl_scl", n_fl_scl, 1);
    chk("post_rst_mlw_cnt", n_mlw, 1);
    chk("post_rst_mlw_dly", t_mlw - t_fl_scl, 31);
    chk("post_rst_no_sda", n_fl_sda + n_rs_sda + n_start + n_stop, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/slv_i2c_io_cond.md
# slv_i2c_io_cond

I2C slave line-conditioning front end, sitting directly upstream of the slave FSM. It synchronises and glitch-filters raw SCL/SDA and produces the filtered levels and single-cycle event strobes that the FSM consumes: SCL/SDA rise and fall edges, START/STOP detection, and mid-low/mid-high SCL phase strobes. The mid-phase strobes are derived from the measured length of the previous SCL phase, so the slave samples and drives SDA away from SCL edges at any bus rate within counter range.

## Interface
- SYNC_STAGES, 2: synchroniser flops per line (≥2)
- FILT_LEN, 4: consecutive stable cycles required to accept a level change (≥1)
- CNT_W, 10: width of the SCL phase counter and length registers
- DEF_HALF, 31: mid-phase offset used when no previous length is known

- CLK  in  1  system clock, 50 MHz
- RST_n  in  1  asynchronous reset, active low
- I_IO_SCL  in  1  raw SCL from pad, asynchronous
- I_IO_SDA  in  1  raw SDA from pad, asynchronous
- O_SCL  out  1  filtered SCL level
- O_SDA  out  1  filtered SDA level
- O_RS_IO_SCL / O_FL_IO_SCL  out  1  one-cycle rise / fall strobes of O_SCL
- O_RS_IO_SDA / O_FL_IO_SDA  out  1  one-cycle rise / fall strobes of O_SDA
- O_START  out  1  one-cycle strobe: O_SDA falls while O_SCL = 1
- O_STOP  out  1  one-cycle strobe: O_SDA rises while O_SCL = 1
- O_MDL_LW_IO_SCL  out  1  one-cycle strobe at the middle of each SCL low phase
- O_MDL_HG_IO_SCL  out  1  one-cycle strobe at the middle of each SCL high phase

## Operation
- Single clock domain: CLK. RST_n is asynchronous, active low.
- Reset values: sync chains = 1, O_SCL = O_SDA = 1, all strobes = 0, filter counters = 0, ph_cnt = 0, len_lw = len_hg = 0.
- Sync: each raw line passes through SYNC_STAGES flops. The last stage is s_scl / s_sda.
- Filter (per line, independent):
  - If s_x ≠ O_x, flt_cnt increments; otherwise it clears to 0.
  - When flt_cnt reaches FILT_LEN−1 and s_x still differs, O_x toggles and flt_cnt clears.
  - Any return of s_x to O_x before then discards the change (glitch rejected).
- Edge strobes: asserted in the first cycle O_x shows its new value, for exactly one cycle.
- START/STOP:
  - O_START = O_FL_IO_SDA & O_SCL; O_STOP = O_RS_IO_SDA & O_SCL.
  - Simultaneous SCL and SDA edges evaluate against the O_SCL value of that same cycle.
- Phase measurement:
  - ph_cnt is 0 in every cycle where an SCL edge strobe is high. Otherwise it increments by 1 per cycle, saturating at 2^CNT_W−1.
  - On O_RS_IO_SCL, len_lw ← min(ph_cnt_prev+1, 2^CNT_W−1), where ph_cnt_prev is the value in the preceding cycle. On O_FL_IO_SCL, len_hg is captured the same way.
- Mid strobes:
  - half_lw = len_lw>>1, or DEF_HALF if len_lw = 0, clamped to a minimum of 1. half_hg is derived the same way from len_hg.
  - O_MDL_LW_IO_SCL = (O_SCL = 0) & (ph_cnt = half_lw) & ¬edge strobe. O_MDL_HG_IO_SCL is the equivalent for the high phase.
  - At most one mid strobe per phase.
  - If the phase ends before reaching half, no strobe is issued.
  - If ph_cnt saturates, the strobe cannot repeat.
- No combinational path from input ports to any output; all outputs decode from registers.

## Timing
- Raw edge to O_x change and edge strobe: SYNC_STAGES + FILT_LEN cycles (6 at defaults), provided the input is stable throughout.
- A raw pulse of fewer than FILT_LEN synchronised cycles produces no output change.
- Mid-low strobe: half_lw cycles after O_FL_IO_SCL.
- Mid-high strobe: half_hg cycles after O_RS_IO_SCL.
- The first low and high phases after reset use DEF_HALF.
- RST_n asserted mid-transfer returns every register to its reset value immediately. After release, the first phases use DEF_HALF again and no spurious strobes are issued, because O_SCL/O_SDA restart at 1.

## Test plan
- Reset, lines held high: O_SCL = O_SDA = 1 and all strobes 0 for 100 cycles; release RST_n with I_IO_SDA = 0: O_FL_IO_SDA and O_START pulse once, 6 cycles after the reset-synchronised sample.
- 3-cycle low glitch on I_IO_SDA with SCL high: no O_SDA change, no strobes; 4-cycle low glitch: O_FL_IO_SDA + O_START, then O_RS_IO_SDA + O_STOP.
- SCL square wave, low 63 / high 62 cycles, from reset:
  - First low phase: mid-low at 31 cycles after O_FL_IO_SCL.
  - Next low phase: mid-low at 31 cycles (63>>1).
  - High phases after the first: mid-high at 31 cycles (62>>1).
- SCL low held 1500 cycles: ph_cnt saturates at 1023, len_lw = 1023, next mid-low at 511; no repeated strobe during saturation.
- SDA rises during SCL low: O_RS_IO_SDA only, no O_STOP; SDA and SCL raw edges in the same cycle: strobes coincide, START/STOP qualified by the O_SCL value of that cycle.
- RST_n pulsed mid-byte (SCL low): all outputs at reset values within the same cycle; after release, the mid-low offset reverts to DEF_HALF.
